// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO between the CPU write path and the UART transmitter
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int THRESHOLD  = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_n,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  empty,
  output logic                  full,
  output logic                  level_hit,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   THRESH_C = (ADDR_WIDTH+1)'(THRESHOLD);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;

  logic empty_w, full_w, wr_acc, rd_acc, wr_drop;

  // Flags come only from the registered count, so acceptance is judged on start-of-cycle state.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);
  assign wr_acc  = wr_en && !full_w && !flush;
  assign rd_acc  = !rd_en_n && !empty_w && !flush;
  assign wr_drop = wr_en && full_w && !flush;

  always_comb begin
    mem_d = mem_q;
    if (wr_acc) begin
      mem_d[wptr_q] = wr_data;
    end
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rptr_d    = rptr_q + PTR_ONE;
        rd_data_d = mem_q[rptr_q];
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - CNT_ONE;
      end
    end
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign empty     = empty_w;
  assign full      = full_w;
  assign level_hit = (count_q >= THRESH_C);
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a queue model
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int THR = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en_n = 1'b1;
  logic [DW-1:0] rd_data;
  logic          flush = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          empty, full, level_hit, overflow;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .THRESHOLD(THR)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en_n(rd_en_n), .rd_data(rd_data), .flush(flush), .ovf_clr(ovf_clr),
    .empty(empty), .full(full), .level_hit(level_hit), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: a byte queue plus sticky flag and last-read byte.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd = '0;
  bit            m_ovf = 1'b0;
  int            m_size;

  always @(posedge clk) begin
    m_size = mq.size();
    if (!reset_n) begin
      mq.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      if (ovf_clr) m_ovf = 1'b0;
    end else begin
      if (!rd_en_n && m_size != 0) m_rd = mq.pop_front();
      if (wr_en && m_size != DEPTH) mq.push_back(wr_data);
      if (ovf_clr) m_ovf = 1'b0;
      if (wr_en && m_size == DEPTH) m_ovf = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("m_count", int'(count), mq.size());
      chk("m_empty", int'(empty), int'(mq.size() == 0));
      chk("m_full", int'(full), int'(mq.size() == DEPTH));
      chk("m_level", int'(level_hit), int'(mq.size() >= THR));
      chk("m_ovf", int'(overflow), int'(m_ovf));
      chk("m_rd", int'(rd_data), int'(m_rd));
    end
  end

  task automatic drive(input bit w, input int d, input bit rn, input bit f, input bit oc);
    wr_en   = w;
    wr_data = DW'(d);
    rd_en_n = rn;
    flush   = f;
    ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 1, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    idle();
    reset_n = 1'b1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_rd", int'(rd_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    checking = 1'b1;

    drive(1, 8'h41, 1, 0, 0);
    drive(1, 8'h42, 1, 0, 0);
    drive(1, 8'h43, 1, 0, 0);
    chk("t1_count3", int'(count), 3);
    chk("t1_empty0", int'(empty), 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_rd41", int'(rd_data), 8'h41);
    drive(0, 0, 0, 0, 0);
    chk("t1_rd42", int'(rd_data), 8'h42);
    drive(0, 0, 0, 0, 0);
    chk("t1_rd43", int'(rd_data), 8'h43);
    chk("t1_empty1", int'(empty), 1);
    chk("t1_count0", int'(count), 0);

    for (int i = 0; i < 16; i++) drive(1, i, 1, 0, 0);
    chk("t2_full", int'(full), 1);
    drive(1, 8'hAA, 1, 0, 0);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_count16", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("t2_drain", int'(rd_data), i);
    end
    chk("t2_empty", int'(empty), 1);
    drive(0, 0, 1, 0, 1);
    chk("t2_ovfclr", int'(overflow), 0);

    drive(1, 8'h77, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 8'h55, 0, 0, 0);
      chk("t3_count1", int'(count), 1);
      chk("t3_rd", int'(rd_data), (i == 0) ? 8'h77 : 8'h55);
    end
    drive(0, 0, 0, 0, 0);
    chk("t3_last", int'(rd_data), 8'h55);
    chk("t3_empty", int'(empty), 1);

    for (int i = 0; i < 11; i++) drive(1, 8'h20 + i, 1, 0, 0);
    chk("t4_lvl0", int'(level_hit), 0);
    drive(1, 8'h2B, 1, 0, 0);
    chk("t4_lvl1", int'(level_hit), 1);
    drive(0, 0, 0, 0, 0);
    chk("t4_lvl_back", int'(level_hit), 0);
    chk("t4_rd20", int'(rd_data), 8'h20);

    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("t5_rd_hold", int'(rd_data), 8'h20);
    for (int i = 0; i < 5; i++) drive(1, 8'h30 + i, 1, 0, 0);
    chk("t5_count5", int'(count), 5);
    drive(1, 8'hEE, 0, 1, 0);
    chk("t5_fl_count", int'(count), 0);
    chk("t5_fl_empty", int'(empty), 1);
    chk("t5_fl_rd", int'(rd_data), 8'h20);
    drive(1, 8'h60, 1, 0, 0);
    drive(1, 8'h61, 0, 0, 0);
    drive(1, 8'hAB, 1, 0, 0);
    for (int i = 0; i < 14; i++) drive(1, i, 1, 0, 0);
    drive(1, 8'hCD, 1, 0, 0);
    chk("t5_ovf_pre", int'(overflow), 1);
    reset_n = 1'b0;
    drive(1, 8'h62, 0, 1, 0);
    reset_n = 1'b1;
    chk("t5_rst_count", int'(count), 0);
    chk("t5_rst_empty", int'(empty), 1);
    chk("t5_rst_full", int'(full), 0);
    chk("t5_rst_lvl", int'(level_hit), 0);
    chk("t5_rst_ovf", int'(overflow), 0);
    chk("t5_rst_rd", int'(rd_data), 0);

    drive(1, 8'h99, 0, 0, 0);
    chk("t6_empty_rw", int'(count), 1);
    chk("t6_empty_rd", int'(rd_data), 0);
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 16; i++) drive(1, 8'h80 + i, 1, 0, 0);
    drive(1, 8'hEE, 0, 0, 1);
    chk("t6_count15", int'(count), 15);
    chk("t6_ovf_set", int'(overflow), 1);
    chk("t6_rd80", int'(rd_data), 8'h80);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("t6_drain", int'(rd_data), 8'h80 + i);
    end
    chk("t6_empty", int'(empty), 1);
    idle();

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
